// File: rtl/run_monitor_pkg.sv
// Shared definitions for the run monitor: FSM states, readout indices and LEDR layout.
package run_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_DONE    = 2'b10,
        ST_TIMEOUT = 2'b11
    } state_t;

    // Readout index map; event channels follow RD_EV_BASE contiguously.
    localparam int unsigned RD_CYCLES  = 0;
    localparam int unsigned RD_INSTR   = 1;
    localparam int unsigned RD_EV_BASE = 2;

    localparam int unsigned LED_W         = 10;
    localparam int unsigned LED_STATE_LSB = 0;
    localparam int unsigned LED_FINISHED  = 2;
    localparam int unsigned LED_TIMED_OUT = 3;
    localparam int unsigned LED_CYC_LSB   = 4;
    localparam int unsigned LED_CYC_W     = 6;

endpackage

// File: rtl/run_monitor_sat_counter.sv
// Saturating up-counter with synchronous zero; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             zero,
    input  logic             en,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (zero) begin
            count <= '0;
        end else if (en && inc && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/run_monitor.sv
// Program-run performance monitor: counts cycles, retired instructions and events
// between a start pulse and a done edge (or timeout), with registered readout.
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned NUM_EV  = 4,
    parameter int unsigned TIMEOUT = 1000000,
    localparam int unsigned SEL_W  = $clog2(NUM_EV + 2)
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic              start,
    input  logic              done,
    input  logic              instr_retire,
    input  logic [NUM_EV-1:0] ev,
    input  logic              clear,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic              busy,
    output logic              finished,
    output logic              timed_out,
    output logic [LED_W-1:0]  LEDR
);

    localparam int unsigned     NUM_CNT   = NUM_EV + 2;
    localparam logic [63:0]     TIMEOUT_L = 64'(TIMEOUT);

    state_t               state;
    state_t               state_next;
    logic                 done_q;
    logic                 done_rise_c;
    logic                 timeout_hit_c;
    logic                 zero_c;
    logic                 run_c;
    logic [NUM_CNT-1:0]   inc_vec;
    logic [CNT_W-1:0]     cnt [NUM_CNT];
    logic [CNT_W-1:0]     rd_mux_c;
    logic [LED_CYC_W-1:0] led_cyc;

    // Resets high so a done level present through reset is not taken as an edge.
    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            done_q <= 1'b1;
        end else begin
            done_q <= done;
        end
    end

    assign done_rise_c   = done & ~done_q;
    // Fires on the edge where the cycle count would reach TIMEOUT.
    assign timeout_hit_c = (64'(cnt[RD_CYCLES]) + 64'd1) >= TIMEOUT_L;

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (done_rise_c) begin
                        state_next = ST_DONE;
                    end else if (timeout_hit_c) begin
                        state_next = ST_TIMEOUT;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    // Status flags track the state register one-for-one.
    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            busy      <= 1'b0;
            finished  <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            busy      <= (state_next == ST_RUN);
            finished  <= (state_next == ST_DONE);
            timed_out <= (state_next == ST_TIMEOUT);
        end
    end

    assign zero_c = clear | ((state == ST_IDLE) & start);
    assign run_c  = (state == ST_RUN);

    always_comb begin
        inc_vec                      = '0;
        inc_vec[RD_CYCLES]           = 1'b1;
        inc_vec[RD_INSTR]            = instr_retire;
        inc_vec[RD_EV_BASE +: NUM_EV] = ev;
    end

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (CLOCK_50),
            .rst_n (rst),
            .zero  (zero_c),
            .en    (run_c),
            .inc   (inc_vec[i]),
            .count (cnt[i])
        );
    end

    always_comb begin
        rd_mux_c = '0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_mux_c = cnt[i];
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_mux_c;
        end
    end

    // Top six cycle-counter bits; narrow counters are left-aligned.
    if (CNT_W >= LED_CYC_W) begin : g_led_wide
        assign led_cyc = cnt[RD_CYCLES][CNT_W-1 -: LED_CYC_W];
    end else begin : g_led_narrow
        assign led_cyc = {cnt[RD_CYCLES], {(LED_CYC_W - CNT_W){1'b0}}};
    end

    always_comb begin
        LEDR                             = '0;
        LEDR[LED_STATE_LSB +: 2]         = state;
        LEDR[LED_FINISHED]               = finished;
        LEDR[LED_TIMED_OUT]              = timed_out;
        LEDR[LED_CYC_LSB +: LED_CYC_W]   = led_cyc;
    end

endmodule

// File: tb/tb_run_monitor.sv
// Bench for run_monitor: directed scenarios, a readout vector table and a random phase
// checked against an arithmetic reference model of two differently-sized instances.
module tb_run_monitor;

    localparam int unsigned NUM_EV = 4;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned W0     = 32;
    localparam int unsigned W1     = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start = 1'b0;
    logic              done = 1'b0;
    logic              instr_retire = 1'b0;
    logic              clear = 1'b0;
    logic [NUM_EV-1:0] ev = '0;
    logic [SEL_W-1:0]  rd_sel = '0;

    logic [W0-1:0] rd_data0;
    logic          busy0, fin0, to0;
    logic [9:0]    led0;
    logic [W1-1:0] rd_data1;
    logic          busy1, fin1, to1;
    logic [9:0]    led1;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    run_monitor #(.CNT_W(W0), .NUM_EV(NUM_EV), .TIMEOUT(20)) dut0 (
        .CLOCK_50(clk), .rst(rst), .start(start), .done(done),
        .instr_retire(instr_retire), .ev(ev), .clear(clear), .rd_sel(rd_sel),
        .rd_data(rd_data0), .busy(busy0), .finished(fin0), .timed_out(to0), .LEDR(led0)
    );

    run_monitor #(.CNT_W(W1), .NUM_EV(NUM_EV), .TIMEOUT(1000)) dut1 (
        .CLOCK_50(clk), .rst(rst), .start(start), .done(done),
        .instr_retire(instr_retire), .ev(ev), .clear(clear), .rd_sel(rd_sel),
        .rd_data(rd_data1), .busy(busy1), .finished(fin1), .timed_out(to1), .LEDR(led1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_RUN, M_DONE, M_TO} mode_e;
    mode_e           m_mode [2];
    longint unsigned m_cnt  [2][6];
    longint unsigned m_rd   [2];
    logic            m_done_prev;

    function automatic longint unsigned cmax(input int k);
        return (k == 0) ? 64'hFFFF_FFFF : 64'd15;
    endfunction

    function automatic longint unsigned tlim(input int k);
        return (k == 0) ? 64'd20 : 64'd1000;
    endfunction

    function automatic longint unsigned sat_add(input longint unsigned v, input logic inc,
                                                input longint unsigned mx);
        return (inc && v < mx) ? v + 1 : v;
    endfunction

    function automatic logic [1:0] mode_code(input mode_e m);
        case (m)
            M_RUN:   return 2'b01;
            M_DONE:  return 2'b10;
            M_TO:    return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic model_reset();
        m_done_prev = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = M_IDLE;
            m_rd[k]   = 0;
            for (int j = 0; j < 6; j++) m_cnt[k][j] = 0;
        end
    endtask

    always @(negedge rst) model_reset();

    always @(posedge clk) begin
        logic            rise;
        longint unsigned old_cyc;
        if (rst === 1'b1) begin
            rise        = done && !m_done_prev;
            m_done_prev = done;
            for (int k = 0; k < 2; k++) begin
                old_cyc = m_cnt[k][0];
                m_rd[k] = (rd_sel < 6) ? m_cnt[k][rd_sel] : 0;
                if (clear) begin
                    m_mode[k] = M_IDLE;
                    for (int j = 0; j < 6; j++) m_cnt[k][j] = 0;
                end else if (m_mode[k] == M_IDLE && start) begin
                    m_mode[k] = M_RUN;
                    for (int j = 0; j < 6; j++) m_cnt[k][j] = 0;
                end else if (m_mode[k] == M_RUN) begin
                    m_cnt[k][0] = sat_add(m_cnt[k][0], 1'b1, cmax(k));
                    m_cnt[k][1] = sat_add(m_cnt[k][1], instr_retire, cmax(k));
                    for (int j = 0; j < 4; j++)
                        m_cnt[k][2+j] = sat_add(m_cnt[k][2+j], ev[j], cmax(k));
                    if (rise) m_mode[k] = M_DONE;
                    else if (old_cyc + 1 >= tlim(k)) m_mode[k] = M_TO;
                end
            end
        end
    end

    task automatic check_model();
        logic [63:0] exp_led;
        exp_led = ((m_cnt[0][0] >> 26) << 4) | (64'(m_mode[0] == M_TO) << 3)
                | (64'(m_mode[0] == M_DONE) << 2) | 64'(mode_code(m_mode[0]));
        chk("m_busy0", busy0, m_mode[0] == M_RUN);
        chk("m_fin0",  fin0,  m_mode[0] == M_DONE);
        chk("m_to0",   to0,   m_mode[0] == M_TO);
        chk("m_rd0",   rd_data0, m_rd[0]);
        chk("m_led0",  led0, exp_led);
        chk("m_busy1", busy1, m_mode[1] == M_RUN);
        chk("m_fin1",  fin1,  m_mode[1] == M_DONE);
        chk("m_rd1",   rd_data1, m_rd[1]);
        chk("m_led1",  led1[3:0], {m_mode[1] == M_TO, m_mode[1] == M_DONE, mode_code(m_mode[1])});
    endtask

    // ---------------- readout vector table ----------------
    typedef struct {
        logic        st;
        logic [3:0]  evv;
        logic [2:0]  sel;
        logic        clr;
        logic        exp_busy;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [15];

    initial begin
        tbl[0]  = '{1'b1, 4'b0000, 3'd0, 1'b0, 1'b1, 32'd0};
        tbl[1]  = '{1'b0, 4'b0101, 3'd0, 1'b0, 1'b1, 32'd0};
        tbl[2]  = '{1'b0, 4'b0101, 3'd0, 1'b0, 1'b1, 32'd1};
        tbl[3]  = '{1'b0, 4'b0101, 3'd0, 1'b0, 1'b1, 32'd2};
        tbl[4]  = '{1'b0, 4'b0101, 3'd0, 1'b0, 1'b1, 32'd3};
        tbl[5]  = '{1'b0, 4'b0101, 3'd0, 1'b0, 1'b1, 32'd4};
        tbl[6]  = '{1'b0, 4'b0000, 3'd2, 1'b0, 1'b1, 32'd5};
        tbl[7]  = '{1'b0, 4'b0000, 3'd4, 1'b0, 1'b1, 32'd5};
        tbl[8]  = '{1'b0, 4'b0000, 3'd3, 1'b0, 1'b1, 32'd0};
        tbl[9]  = '{1'b0, 4'b0000, 3'd5, 1'b0, 1'b1, 32'd0};
        tbl[10] = '{1'b0, 4'b0000, 3'd7, 1'b0, 1'b1, 32'd0};
        tbl[11] = '{1'b0, 4'b0000, 3'd1, 1'b0, 1'b1, 32'd0};
        tbl[12] = '{1'b0, 4'b0000, 3'd0, 1'b0, 1'b1, 32'd11};
        tbl[13] = '{1'b0, 4'b0000, 3'd0, 1'b1, 1'b0, 32'd12};
        tbl[14] = '{1'b0, 4'b0000, 3'd2, 1'b0, 1'b0, 32'd0};

        // Reset state
        rst = 1'b0;
        step();
        step();
        chk("rst_busy", busy0, 0);
        chk("rst_fin", fin0, 0);
        chk("rst_to", to0, 0);
        chk("rst_rd", rd_data0, 0);
        chk("rst_led", led0, 0);
        rst = 1'b1;

        // Basic run ended by done edge
        start = 1'b1;
        step();
        start = 1'b0;
        chk("a_busy", busy0, 1);
        chk("a_led_run", led0[1:0], 2'b01);
        for (int i = 0; i < 10; i++) begin
            instr_retire = (i < 7);
            step();
        end
        instr_retire = 1'b0;
        done = 1'b1;
        step();
        chk("a_fin", fin0, 1);
        chk("a_busy_end", busy0, 0);
        chk("a_led_state", led0[1:0], 2'b10);
        chk("a_led_fin", led0[2], 1);
        rd_sel = 3'd0;
        step();
        chk("a_cycles", rd_data0, 11);
        chk("a_cycles_w4", rd_data1, 11);
        rd_sel = 3'd1;
        step();
        chk("a_instr", rd_data0, 7);
        done = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("a_clear_led", led0, 0);

        // Timeout after 20 run cycles
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (19) step();
        chk("b_busy19", busy0, 1);
        chk("b_to19", to0, 0);
        step();
        chk("b_to", to0, 1);
        chk("b_busy", busy0, 0);
        chk("b_led_state", led0[1:0], 2'b11);
        chk("b_led_to", led0[3], 1);
        rd_sel = 3'd0;
        step();
        chk("b_cycles", rd_data0, 20);
        clear = 1'b1;
        step();
        clear = 1'b0;

        // Saturation on the 4-bit instance
        start = 1'b1;
        step();
        start = 1'b0;
        instr_retire = 1'b1;
        repeat (30) step();
        instr_retire = 1'b0;
        rd_sel = 3'd1;
        step();
        chk("c_instr_sat", rd_data1, 15);
        chk("c_busy_w4", busy1, 1);
        rd_sel = 3'd0;
        step();
        chk("c_cycles_sat", rd_data1, 15);
        clear = 1'b1;
        step();
        clear = 1'b0;

        // Readout map table
        for (int i = 0; i < 15; i++) begin
            start  = tbl[i].st;
            ev     = tbl[i].evv;
            rd_sel = tbl[i].sel;
            clear  = tbl[i].clr;
            step();
            chk($sformatf("tbl%0d_busy", i), busy0, tbl[i].exp_busy);
            chk($sformatf("tbl%0d_rd", i), rd_data0, tbl[i].exp_rd);
        end
        start = 1'b0;
        clear = 1'b0;
        ev    = '0;

        // Asynchronous reset mid-run
        instr_retire = 1'b1;
        ev = '1;
        rd_sel = 3'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        chk("e_pre_rd", rd_data0, 4);
        chk("e_pre_busy", busy0, 1);
        rst = 1'b0;
        #2;
        chk("e_rst_busy", busy0, 0);
        chk("e_rst_rd", rd_data0, 0);
        chk("e_rst_led", led0, 0);
        chk("e_rst_rd_w4", rd_data1, 0);
        chk("e_rst_fin", fin0, 0);
        step();
        rst = 1'b1;
        instr_retire = 1'b0;
        ev = '0;
        rd_sel = 3'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("e_restart_busy", busy0, 1);
        repeat (3) step();
        step();
        chk("e_fresh_cycles", rd_data0, 3);
        rd_sel = 3'd1;
        step();
        chk("e_fresh_instr", rd_data0, 0);
        chk("e_no_done", fin0, 0);
        chk("e_no_to", to0, 0);

        // done held high through reset, then done coinciding with timeout
        done = 1'b1;
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("f_busy_start", busy0, 1);
        for (int i = 1; i <= 19; i++) begin
            done = (i <= 5);
            step();
        end
        chk("f_busy19", busy0, 1);
        chk("f_fin19", fin0, 0);
        done = 1'b1;
        step();
        chk("f_fin", fin0, 1);
        chk("f_to", to0, 0);
        chk("f_led_state", led0[1:0], 2'b10);
        rd_sel = 3'd0;
        step();
        chk("f_cycles", rd_data0, 20);
        clear = 1'b1;
        step();
        clear = 1'b0;

        // Random phase against the reference model
        for (int n = 0; n < 3000; n++) begin
            start        = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) done = ~done;
            instr_retire = 1'($urandom_range(0, 1));
            ev           = NUM_EV'($urandom);
            clear        = ($urandom_range(0, 59) == 0);
            rd_sel       = SEL_W'($urandom);
            step();
            check_model();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/run_monitor.md
RUN_MONITOR -- requirements
Module: run_monitor

Interface
REQ-001 Parameter CNT_W, default 32, width of every counter and of rd_data.
REQ-002 Parameter NUM_EV, default 4, number of generic event channels (1..16).
REQ-003 Parameter TIMEOUT, default 1000000, cycle limit for a run before abort.
REQ-004 Port CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous and active-low.
REQ-006 Port start  input  1  one-cycle pulse that begins a run.
REQ-007 Port done  input  1  CPU end-of-program level; rising edge ends the run.
REQ-008 Port instr_retire  input  1  one instruction retired this cycle.
REQ-009 Port ev  input  NUM_EV  per-channel event strobes, one count per high cycle.
REQ-010 Port clear  input  1  synchronous clear of all counters and flags.
REQ-011 Port rd_sel  input  SEL_W = clog2(NUM_EV+2)  readout index.
REQ-012 Port rd_data  output  CNT_W  registered counter value selected by rd_sel.
REQ-013 Port busy  output  1  high while in RUN.
REQ-014 Port finished  output  1  high in DONE.
REQ-015 Port timed_out  output  1  high in TIMEOUT.
REQ-016 Port LEDR  output  10  status display for the board.

Function
REQ-017 FSM states IDLE, RUN, DONE and TIMEOUT, encoded 2'b00, 2'b01, 2'b10 and 2'b11.
REQ-018 IDLE->RUN on start; RUN->DONE on done rising edge; RUN->TIMEOUT when cycle counter reaches TIMEOUT; DONE/TIMEOUT->IDLE on clear.
REQ-019 start outside IDLE is ignored; start in IDLE also zeroes all counters in the same edge.
REQ-020 Done edge detection uses a registered copy of done, and the copy resets to 1 so that a done already high at reset does not register as an edge.
REQ-021 In RUN the cycle counter increments every cycle, including the cycle the run ends (the start cycle is not counted).
REQ-022 In RUN the instruction counter increments when instr_retire=1, and event counter k increments when ev[k]=1.
REQ-023 All counters saturate at 2^CNT_W-1 and never wrap.
REQ-024 Counters hold their value outside RUN.
REQ-025 If done rises in the same cycle the timeout is reached, the transition goes to DONE.
REQ-026 clear has priority over start and over every count, and returns the FSM to IDLE from any state, including RUN.
REQ-027 Readout map: rd_sel 0 = cycles, 1 = instructions, 2..NUM_EV+1 = ev[0..NUM_EV-1], other values = 0.
REQ-028 Readout latency is one cycle, and rd_data shows counter values as of the previous edge.
REQ-029 LEDR[1:0] = state, LEDR[2] = finished, LEDR[3] = timed_out, LEDR[9:4] = cycle counter bits [CNT_W-1:CNT_W-6].

Reset
REQ-030 Asserting rst (low) immediately forces state IDLE, all counters 0, rd_data 0 and busy/finished/timed_out 0, so LEDR = 0.
REQ-031 When rst asserts mid-run, counts are discarded and no DONE or TIMEOUT is reported.
REQ-032 After rst deasserts, the first start is accepted on the next rising edge.

Structure
REQ-033 The shared package holds the state enum, the readout index constants (RD_CYCLES = 0, RD_INSTR = 1, RD_EV_BASE = 2) and the LEDR field positions.
REQ-034 The sub-module sat_counter (CNT_W, with inc, zero and en inputs) is instantiated NUM_EV+2 times.
REQ-035 All synchronous logic uses a single always block per register group, with no latches and no gated clocks.

Verification
REQ-036 Reset, then start, then 10 cycles with instr_retire high for 7 of them, then done rises: bench reads cycles=11, instr=7 and requires finished=1, LEDR[1:0]=2'b10.
REQ-037 With TIMEOUT=20, start and never assert done: timed_out=1 after 20 RUN cycles, cycles=20, busy=0.
REQ-038 With CNT_W=4, start and hold instr_retire for 30 cycles: instr=15 (saturated) with no wrap.
REQ-039 ev=4'b0101 held for 5 RUN cycles: rd_sel 2 then 4 read 5, rd_sel 3 and 5 read 0, rd_sel 7 reads 0.
REQ-040 Pull rst low at RUN cycle 6: all outputs go to 0 asynchronously, and a later start gives a fresh count from 0.
REQ-041 Assert done high through reset, then start: the run does not end until done falls and rises again, and done and timeout in the same cycle result in DONE.
